// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neuron datapath (lif array, AER encoder,
// top level): default widths/depths, address-width helper and the default
// AER event word layout.
// ----------------------------------------------------------------------------
package snn_pkg;

    localparam int unsigned N_NEURONS_DEF  = 4;
    localparam int unsigned TS_W_DEF       = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    // Address width for n neurons; never below one bit so a single neuron
    // still gets a real address field.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ADDR_W_DEF = addr_w(N_NEURONS_DEF);

    // AER word at the default widths, MSBs = neuron address.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [TS_W_DEF-1:0]   ts;
    } aer_event_t;

endpackage

// File: rtl/aer_fifo.sv
// ----------------------------------------------------------------------------
// aer_fifo
// Synchronous show-ahead FIFO with a registered head word.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (discards all contents)
//   i_push   in   write i_wdata (ignored when full without a pop)
//   i_wdata  in   W-bit write data
//   i_pop    in   consume the presented head word (when o_valid)
//   o_valid  out  registered: head word is presented
//   o_data   out  registered head word, stable until popped
//   o_full   out  occupancy == DEPTH
//   o_empty  out  occupancy == 0
//   o_count  out  occupancy, including the presented word
// DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module aer_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic [W-1:0]  r_data;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic [PW-1:0] w_rd_next;
    logic [CW-1:0] w_count_after_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    assign w_pop_ok          = i_pop && r_valid;
    assign w_push_ok         = i_push && (!o_full || w_pop_ok);
    assign w_rd_next         = r_rd_ptr + PW'(w_pop_ok);
    assign w_count_after_pop = r_count - CW'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // The head register is refreshed from entries that were already stored
    // before this edge, so a word written now becomes visible one edge later.
    // That keeps the head a plain copy of r_mem[r_rd_ptr] whenever r_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            r_valid  <= (w_count_after_pop != '0);
            if (w_count_after_pop != '0) begin
                r_data <= r_mem[w_rd_next];
            end
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// ----------------------------------------------------------------------------
// spike_aer_encoder
// Converts rising edges on per-neuron spike lines into AER words
// {neuron address, timestamp}, buffers them and presents them on a
// valid/ready port. Simultaneous spikes are serialised lowest index first.
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   low: timestamp frozen, no capture (queue still drains)
//   spike_in    in   spike lines, bit i = neuron i
//   aer_valid   out  event word presented
//   aer_ready   in   consumer accepts when aer_valid && aer_ready
//   aer_addr    out  neuron index of the presented event
//   aer_ts      out  timestamp of the presented event
//   fifo_count  out  FIFO occupancy
//   overflow    out  sticky, set when an event is dropped
//   drop_cnt    out  saturating count of dropped events
//                    (only with AER_DROP_COUNT_EN defined)
// ----------------------------------------------------------------------------
module spike_aer_encoder
    import snn_pkg::*;
#(
    parameter int unsigned N_NEURONS  = N_NEURONS_DEF,
    parameter int unsigned TS_W       = TS_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned ADDR_W    = addr_w(N_NEURONS),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [ADDR_W-1:0]    aer_addr,
    output logic [TS_W-1:0]      aer_ts,
    output logic [CNT_W-1:0]     fifo_count,
`ifdef AER_DROP_COUNT_EN
    output logic [7:0]           drop_cnt,
`endif
    output logic                 overflow
);

    localparam int unsigned EW = ADDR_W + TS_W;

    logic [TS_W-1:0]      r_ts;
    logic [N_NEURONS-1:0] r_spike_prev;
    logic [N_NEURONS-1:0] r_pending;
    logic [TS_W-1:0]      r_pend_ts [N_NEURONS];
    logic                 r_overflow;

    logic [N_NEURONS-1:0] w_edge;
    logic [N_NEURONS-1:0] w_grant;
    logic [N_NEURONS-1:0] w_drop;
    logic                 w_push;
    logic [ADDR_W-1:0]    w_grant_addr;
    logic [TS_W-1:0]      w_grant_ts;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [EW-1:0]        w_head;

    assign w_edge   = ena ? (spike_in & ~r_spike_prev) : '0;
    assign w_pop    = aer_valid && aer_ready && !w_empty;
    // A pending line that is not leaving this cycle cannot take a new event.
    assign w_drop   = w_edge & r_pending & ~w_grant;
    assign overflow = r_overflow;
    assign aer_addr = w_head[EW-1:TS_W];
    assign aer_ts   = w_head[TS_W-1:0];

    // Fixed priority: lowest set pending bit, one push per cycle, only when
    // the FIFO has room or frees a slot this cycle.
    always_comb begin
        w_grant      = '0;
        w_push       = 1'b0;
        w_grant_addr = '0;
        w_grant_ts   = '0;
        if (!w_full || w_pop) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                if (r_pending[i] && !w_push) begin
                    w_push       = 1'b1;
                    w_grant[i]   = 1'b1;
                    w_grant_addr = ADDR_W'(i);
                    w_grant_ts   = r_pend_ts[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts         <= '0;
            r_spike_prev <= '0;
            r_pending    <= '0;
            r_overflow   <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                r_pend_ts[i] <= '0;
            end
        end else begin
            r_spike_prev <= spike_in;
            if (ena) begin
                r_ts <= r_ts + 1'b1;
            end
            r_pending <= (r_pending & ~w_grant) | w_edge;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                if (w_edge[i] && !w_drop[i]) begin
                    r_pend_ts[i] <= r_ts;
                end
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef AER_DROP_COUNT_EN
    logic [7:0] r_drop_cnt;
    logic [8:0] w_drop_n;
    logic [9:0] w_drop_sum;

    always_comb begin
        w_drop_n = '0;
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
            w_drop_n = w_drop_n + 9'(w_drop[i]);
        end
        w_drop_sum = {2'b00, r_drop_cnt} + {1'b0, w_drop_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > 10'd255) begin
            r_drop_cnt <= 8'hFF;
        end else begin
            r_drop_cnt <= w_drop_sum[7:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    aer_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({w_grant_addr, w_grant_ts}),
        .i_pop   (w_pop),
        .o_valid (aer_valid),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

endmodule

// File: tb/tb_spike_aer_encoder.sv
// ----------------------------------------------------------------------------
// tb_spike_aer_encoder
// Directed bench for spike_aer_encoder at default parameters (4 neurons,
// 4-bit timestamp, 8-entry FIFO). Honours AER_DROP_COUNT_EN.
// ----------------------------------------------------------------------------
module tb_spike_aer_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] spike_in;
    logic       aer_valid;
    logic       aer_ready;
    logic [1:0] aer_addr;
    logic [3:0] aer_ts;
    logic [3:0] fifo_count;
    logic       overflow;
`ifdef AER_DROP_COUNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int tb_ts    = 0;   // expected value of the DUT timestamp counter
    int n_ev;
    int exp_ts [10];
    int ts_frozen;

    always #5 clk = ~clk;

    spike_aer_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .aer_addr   (aer_addr),
        .aer_ts     (aer_ts),
        .fifo_count (fifo_count),
`ifdef AER_DROP_COUNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs were set at the previous negedge, outputs are
    // sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        if (ena && rst_n) tb_ts = (tb_ts + 1) % 16;
        @(negedge clk);
    endtask

    task automatic advance_to(input int t);
        for (int k = 0; k < 32 && tb_ts != t; k++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; spike_in = '0; aer_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", aer_valid, 0);
        check("rst_addr", aer_addr, 0);
        check("rst_ts", aer_ts, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1; ena = 1'b1;

        // 1. single spike at ts=3
        advance_to(3);
        spike_in = 4'b0100; tick();
        spike_in = 4'b0000; tick();
        check("t1_valid_early", aer_valid, 0);
        tick();
        check("t1_valid", aer_valid, 1);
        check("t1_addr", aer_addr, 2);
        check("t1_ts", aer_ts, 3);
        check("t1_count1", fifo_count, 1);
        tick();
        check("t1_valid_drop", aer_valid, 0);
        check("t1_count0", fifo_count, 0);

        // 2. simultaneous spikes at ts=5
        advance_to(5);
        spike_in = 4'b1011; tick();
        spike_in = 4'b0000; tick(); tick();
        check("t2_v0", aer_valid, 1); check("t2_a0", aer_addr, 0); check("t2_ts0", aer_ts, 5);
        tick();
        check("t2_v1", aer_valid, 1); check("t2_a1", aer_addr, 1); check("t2_ts1", aer_ts, 5);
        tick();
        check("t2_v3", aer_valid, 1); check("t2_a3", aer_addr, 3); check("t2_ts3", aer_ts, 5);
        tick();
        check("t2_end", aer_valid, 0);

        // 3. backpressure until full, 9th event held pending
        aer_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            spike_in = 4'(1 << (j % 4)); exp_ts[j] = tb_ts; tick();
            spike_in = 4'b0000; tick();
        end
        check("t3_count8", fifo_count, 8);
        check("t3_valid", aer_valid, 1);
        check("t3_addr", aer_addr, 0);
        check("t3_ts", aer_ts, exp_ts[0]);
        spike_in = 4'b0001; exp_ts[8] = tb_ts; tick();
        spike_in = 4'b0000; repeat (3) tick();
        check("t3_count_hold", fifo_count, 8);
        check("t3_no_overflow", overflow, 0);
        check("t3_addr_stable", aer_addr, 0);
        check("t3_ts_stable", aer_ts, exp_ts[0]);

        // 4. collision on line 1 while full
        spike_in = 4'b0010; exp_ts[9] = tb_ts; tick();
        spike_in = 4'b0000; tick();
        spike_in = 4'b0010; tick();
        spike_in = 4'b0000; tick();
        check("t4_overflow", overflow, 1);
        check("t4_count", fifo_count, 8);
`ifdef AER_DROP_COUNT_EN
        check("t4_drop_cnt", drop_cnt, 1);
`endif

        // drain: 8 queued in capture order, then pending line 0, then line 1
        aer_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            check("t3_drain_valid", aer_valid, 1);
            check("t3_drain_addr", aer_addr, (j < 8) ? (j % 4) : (j - 8));
            check("t3_drain_ts", aer_ts, exp_ts[j]);
            tick();
        end
        check("t3_drain_end", aer_valid, 0);
        check("t3_drain_count", fifo_count, 0);
        check("t4_overflow_sticky", overflow, 1);

        // 5a. held line gives one event
        n_ev = 0;
        spike_in = 4'b0001;
        for (int j = 0; j < 10; j++) begin tick(); if (aer_valid) n_ev++; end
        spike_in = 4'b0000;
        for (int j = 0; j < 4; j++) begin tick(); if (aer_valid) n_ev++; end
        check("t5_held_events", n_ev, 1);

        // 5b. ena=0: no capture, timestamp frozen
        ts_frozen = tb_ts;
        ena = 1'b0; n_ev = 0;
        for (int j = 0; j < 6; j++) begin
            spike_in = (j % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
            if (aer_valid) n_ev++;
        end
        spike_in = 4'b0000; tick(); if (aer_valid) n_ev++;
        check("t5_ena_events", n_ev, 0);
        ena = 1'b1;
        spike_in = 4'b0100; tick();
        spike_in = 4'b0000; tick(); tick();
        check("t5_frozen_valid", aer_valid, 1);
        check("t5_frozen_addr", aer_addr, 2);
        check("t5_frozen_ts", aer_ts, ts_frozen);
        tick();

        // 5c. wrap 15 -> 0
        advance_to(15);
        tick();
        spike_in = 4'b1000; tick();
        spike_in = 4'b0000; tick(); tick();
        check("t5_wrap_valid", aer_valid, 1);
        check("t5_wrap_addr", aer_addr, 3);
        check("t5_wrap_ts", aer_ts, 0);
        tick();

        // 6. asynchronous reset with 5 queued
        aer_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            spike_in = 4'(1 << (j % 4)); tick();
            spike_in = 4'b0000; tick();
        end
        check("t6_count5", fifo_count, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", aer_valid, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_overflow", overflow, 0);
        spike_in = 4'b0001; aer_ready = 1'b1; ena = 1'b1;
        @(negedge clk);
        tb_ts = 0; rst_n = 1'b1;
        tick(); tick(); tick();
        check("t6_valid", aer_valid, 1);
        check("t6_addr", aer_addr, 0);
        check("t6_ts", aer_ts, 0);
        n_ev = 0;
        for (int j = 0; j < 6; j++) begin tick(); if (aer_valid) n_ev++; end
        check("t6_single", n_ev, 0);
        spike_in = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
